shout_clk_bank: RTL
===================

Name: shout_clk_bank

Overview:
- Parametrised bank of NCH independent divided "shout" clocks, all derived from one fast clock.
- Each channel's divisor is runtime-programmable and double-buffered, with optional per-half-period random jitter from the ring RNG.
- Per-channel enable, a global resynchronise pulse and per-channel phase offsets.
- Replaces hand-coded fixed divider chains feeding ps_shout / usb1_shout instances; outputs drive their clk_in.

Parameters:
- NCH, 4, number of output channels (1..16).
- DIV_W, 8, divisor/counter width in bits.
- RND_W, 5, width of rnd input (matches ring_rnd rng_out).
- JIT_W, 2, number of rnd LSBs added as jitter (JIT_W <= RND_W).
- DEF_DIV, 22, reset value of every channel's active and shadow divisor.
- PHASE_STEP, 5, reset/sync counter preload for channel i = (i*PHASE_STEP) mod 2^DIV_W.
- EN_RST, {NCH{1'b1}}, reset value of channel enable bits.

Ports:
- clk_in  in  1  fast clock; all state on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- rnd  in  RND_W  random bits from ring_rnd; treated as synchronous, sampled only at reload.
- wr_en  in  1  configuration write strobe, one cycle.
- wr_ch  in  4  target channel; values >= NCH are ignored.
- wr_div  in  DIV_W  new divisor, written to the shadow register.
- wr_jit  in  1  new jitter-enable bit, written to the shadow register.
- wr_chen  in  1  new channel enable, applied directly (not shadowed).
- sync  in  1  one-cycle pulse: realign all channels.
- clk_out  out  NCH  divided clocks.
- tick  out  NCH  one-cycle pulse, registered, high in the same cycle clk_out[i] changes.

Behaviour:
- Reset state, per channel i:
  - div_act = div_sh = DEF_DIV; jit_act = jit_sh = 0; jit_r = 0.
  - en = EN_RST[i]; cnt = phase_i; clk_out = 0; tick = 0.
- Effective terminal count: term = div_act + (jit_act ? jit_r : 0), computed DIV_W+1 bits wide; never wraps.
- Per cycle, enabled channel, no sync:
  - If cnt >= term: cnt <= 0; clk_out toggles; tick <= 1; div_act <= div_sh; jit_act <= jit_sh; jit_r <= rnd[JIT_W-1:0].
  - Else: cnt <= cnt+1; tick <= 0.
- The ">=" compare guarantees a preload or new divisor below the current cnt toggles on the next cycle; the counter never locks out.
- Half-period = term+1 cycles. Jitter is held constant for the whole half-period.
- Disabled channel: cnt <= 0; clk_out <= 0; tick <= 0. On enable, counting starts from 0; the first toggle comes after div_act+1 cycles.
- Write, when wr_en=1 and wr_ch<NCH:
  - div_sh <= wr_div; jit_sh <= wr_jit; en <= wr_chen.
- Write in the same cycle as that channel's reload: the reload takes the OLD shadow; the new value applies at the following reload.
- Sync pulse, all enabled channels:
  - cnt <= phase_i; clk_out <= 0; tick <= 0; div_act <= div_sh (old shadow if a write is simultaneous); jit_act <= jit_sh; jit_r <= 0.
  - Disabled channels are unaffected by sync.
- Priority: reset > sync > reload/count. A write still updates shadow/enable in the same cycle as sync.
- wr_div = 0: half-period of 1 cycle (clk_in/2) when jitter is off.
- Reset asserted mid-operation: outputs drop to 0 asynchronously; no glitch-free guarantee on clk_out at that instant.

Optional Feature:
- Macro SHOUT_CLK_RNDPH_EN.
- Defined: on sync (not reset), enabled channel i preloads cnt <= rnd zero-extended/truncated to DIV_W, then XOR i.
  - If the preload exceeds term, the channel toggles on the next cycle.
- Undefined: the sync preload is phase_i as above; rnd is not sampled on sync.

Test Plan:
- Reset release, defaults:
  - ch0 (phase 0) clk_out rises on the 23rd clk_in edge after reset release and has period 46.
  - ch1 (phase 5) first toggles on edge 18.
  - tick[0] is high exactly one cycle per toggle.
- Write ch2 wr_div=3 mid-half-period:
  - The current half-period completes with 22.
  - Subsequent half-periods are 4 cycles.
  - A write coincident with the reload edge takes effect one half-period later.
- Jitter on ch0 (wr_div=10, wr_jit=1), rnd[1:0] driven 3,0,2:
  - Half-periods are 11 (jit_r=0 first), then 14, 11, 13.
  - Jitter never changes within a half-period.
- Disable ch3 with wr_chen=0: clk_out[3]=0 next cycle.
  - Re-enable with div_act=22: first toggle 23 cycles later.
  - sync while disabled has no effect on ch3.
- sync pulse during running:
  - All enabled channels restart with ch0..ch3 preloads 0/5/10/15; first toggles at 23/18/13/8 cycles.
  - A write in the sync cycle lands in the shadow only.
- Write with wr_ch=7 (NCH=4): no state change.
- Reset asserted mid-cycle: clk_out/tick go 0 without a clock edge.
- With SHOUT_CLK_RNDPH_EN defined, rnd=31 at sync, div=22: every channel toggles on the next cycle.

Source files
------------

// File: rtl/shout_clk_bank.sv
// rtl/shout_clk_bank.sv - bank of NCH runtime-programmable divided shout clocks from one fast clock
// Optional SHOUT_CLK_RNDPH_EN: sync preloads each counter from rnd instead of the fixed phase ladder.
module shout_clk_bank #(
  parameter int             NCH        = 4,
  parameter int             DIV_W      = 8,
  parameter int             RND_W      = 5,
  parameter int             JIT_W      = 2,
  parameter int             DEF_DIV    = 22,
  parameter int             PHASE_STEP = 5,
  parameter logic [NCH-1:0] EN_RST     = {NCH{1'b1}}
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic [RND_W-1:0] rnd,
  input  logic             wr_en,
  input  logic [3:0]       wr_ch,
  input  logic [DIV_W-1:0] wr_div,
  input  logic             wr_jit,
  input  logic             wr_chen,
  input  logic             sync,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick
);

  // One extra bit so a counter can reach a jittered terminal above 2^DIV_W-1.
  localparam int CNT_W = DIV_W + 1;

  function automatic logic [DIV_W-1:0] phase_of(input int i);
    return DIV_W'(i * PHASE_STEP);
  endfunction

  logic [CNT_W-1:0] cnt_q     [NCH];
  logic [CNT_W-1:0] cnt_d     [NCH];
  logic [DIV_W-1:0] div_act_q [NCH];
  logic [DIV_W-1:0] div_act_d [NCH];
  logic [DIV_W-1:0] div_sh_q  [NCH];
  logic [DIV_W-1:0] div_sh_d  [NCH];
  logic [JIT_W-1:0] jit_r_q   [NCH];
  logic [JIT_W-1:0] jit_r_d   [NCH];
  logic [CNT_W-1:0] term      [NCH];
  logic [DIV_W-1:0] preload   [NCH];

  logic [NCH-1:0] jit_act_q, jit_act_d;
  logic [NCH-1:0] jit_sh_q,  jit_sh_d;
  logic [NCH-1:0] en_q,      en_d;
  logic [NCH-1:0] clk_q,     clk_d;
  logic [NCH-1:0] tick_q,    tick_d;
  logic [NCH-1:0] hit;

  logic unused_rnd;
  assign unused_rnd = ^rnd;

  always_comb begin
    jit_act_d = jit_act_q;
    jit_sh_d  = jit_sh_q;
    en_d      = en_q;
    clk_d     = clk_q;
    tick_d    = '0;
    hit       = '0;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i]     = cnt_q[i];
      div_act_d[i] = div_act_q[i];
      div_sh_d[i]  = div_sh_q[i];
      jit_r_d[i]   = jit_r_q[i];
      term[i]      = CNT_W'(div_act_q[i]) +
                     (jit_act_q[i] ? CNT_W'(jit_r_q[i]) : CNT_W'(0));
`ifdef SHOUT_CLK_RNDPH_EN
      preload[i]   = DIV_W'(rnd) ^ DIV_W'(i);
`else
      preload[i]   = phase_of(i);
`endif

      // Config lands in the shadow; reload and sync below read the old shadow.
      hit[i] = wr_en && (wr_ch == 4'(i));
      if (hit[i]) begin
        div_sh_d[i] = wr_div;
        jit_sh_d[i] = wr_jit;
        en_d[i]     = wr_chen;
      end

      if (!en_q[i]) begin
        cnt_d[i] = '0;
        clk_d[i] = 1'b0;
      end else if (sync) begin
        cnt_d[i]     = CNT_W'(preload[i]);
        clk_d[i]     = 1'b0;
        div_act_d[i] = div_sh_q[i];
        jit_act_d[i] = jit_sh_q[i];
        jit_r_d[i]   = '0;
      end else if (cnt_q[i] >= term[i]) begin
        cnt_d[i]     = '0;
        clk_d[i]     = ~clk_q[i];
        tick_d[i]    = 1'b1;
        div_act_d[i] = div_sh_q[i];
        jit_act_d[i] = jit_sh_q[i];
        jit_r_d[i]   = rnd[JIT_W-1:0];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      jit_act_q <= '0;
      jit_sh_q  <= '0;
      en_q      <= EN_RST;
      clk_q     <= '0;
      tick_q    <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]     <= CNT_W'(phase_of(i));
        div_act_q[i] <= DIV_W'(DEF_DIV);
        div_sh_q[i]  <= DIV_W'(DEF_DIV);
        jit_r_q[i]   <= '0;
      end
    end else begin
      jit_act_q <= jit_act_d;
      jit_sh_q  <= jit_sh_d;
      en_q      <= en_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]     <= cnt_d[i];
        div_act_q[i] <= div_act_d[i];
        div_sh_q[i]  <= div_sh_d[i];
        jit_r_q[i]   <= jit_r_d[i];
      end
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;

endmodule
